spawn_scheduler: RTL and testbench

SPAWN_SCHEDULER -- requirements
Module: spawn_scheduler

---
 rtl/spawn_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_spawn_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spawn_scheduler.sv
// spawn_scheduler: paces produce spawns with a randomised tick gap, then
// builds a spawn descriptor (type, column, upward velocity) from three
// successive random bytes and offers it over a valid/ready handshake.
// Optional feature macro: SPAWN_BOMB_EN (when defined, type 7 "bomb" is
// allowed through; otherwise a captured 7 is folded to type 0).
module spawn_scheduler #(
    parameter int unsigned MIN_GAP  = 4,
    parameter logic [7:0]  GAP_MASK = 8'h0F,
    parameter int unsigned X_MIN    = 32,
    parameter int unsigned X_SPAN   = 576
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       tick,
    input  logic [7:0] rand_in,
    input  logic       spawn_ready,
    output logic       spawn_valid,
    output logic [2:0] spawn_type,
    output logic [9:0] spawn_x,
    output logic [3:0] spawn_vel,
    output logic [7:0] spawn_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GAP    = 3'd1,
        S_TYPE = 3'd2,
        S_X    = 3'd3,
        S_VEL  = 3'd4,
        OFFER  = 3'd5
    } state_t;

    localparam logic [8:0]  MIN_GAP_9 = 9'(MIN_GAP);
    localparam logic [17:0] X_SPAN_18 = 18'(X_SPAN);
    localparam logic [9:0]  X_MIN_10  = 10'(X_MIN);

    // Folds the bomb type away unless the bomb feature is built in.
    function automatic logic [2:0] filter_type(input logic [2:0] t);
`ifdef SPAWN_BOMB_EN
        return t;
`else
        if (t == 3'd7) begin
            return 3'd0;
        end else begin
            return t;
        end
`endif
    endfunction

    state_t      r_state;
    logic [8:0]  r_gap_cnt;
    logic        r_valid;
    logic [2:0]  r_type;
    logic [9:0]  r_x;
    logic [3:0]  r_vel;
    logic [7:0]  r_count;

    state_t      w_state;
    logic [8:0]  w_gap_cnt;
    logic        w_valid;
    logic [2:0]  w_type;
    logic [9:0]  w_x;
    logic [3:0]  w_vel;
    logic [7:0]  w_count;

    logic [8:0]  w_gap_load;
    logic [17:0] w_prod;
    logic [9:0]  w_x_calc;
    logic [3:0]  w_vel_calc;

    // Datapath helpers: gap reload value, scaled spawn column, velocity.
    always_comb begin
        w_gap_load = MIN_GAP_9 + {1'b0, rand_in & GAP_MASK};
        w_prod     = {10'd0, rand_in} * X_SPAN_18;
        w_x_calc   = X_MIN_10 + w_prod[17:8];
        w_vel_calc = 4'd4 + {1'b0, rand_in[7:5]};
    end

    // Next-state and next-register values; everything holds unless changed.
    always_comb begin
        w_state   = r_state;
        w_gap_cnt = r_gap_cnt;
        w_valid   = r_valid;
        w_type    = r_type;
        w_x       = r_x;
        w_vel     = r_vel;
        w_count   = r_count;
        case (r_state)
            IDLE: begin
                w_valid = 1'b0;
                if (enable) begin
                    w_gap_cnt = w_gap_load;
                    w_state   = GAP;
                end else begin
                    w_state   = IDLE;
                end
            end
            GAP: begin
                if (!enable) begin
                    w_state = IDLE;
                end else if (tick) begin
                    // A zero count is unreachable (MIN_GAP >= 1) but is
                    // treated as expired so the counter can never wrap.
                    if (r_gap_cnt <= 9'd1) begin
                        w_state = S_TYPE;
                    end else begin
                        w_gap_cnt = r_gap_cnt - 9'd1;
                    end
                end else begin
                    w_state = GAP;
                end
            end
            S_TYPE: begin
                if (!enable) begin
                    w_state = IDLE;
                end else begin
                    w_type  = filter_type(rand_in[2:0]);
                    w_state = S_X;
                end
            end
            S_X: begin
                if (!enable) begin
                    w_state = IDLE;
                end else begin
                    w_x     = w_x_calc;
                    w_state = S_VEL;
                end
            end
            S_VEL: begin
                if (!enable) begin
                    w_state = IDLE;
                end else begin
                    w_vel   = w_vel_calc;
                    w_valid = 1'b1;
                    w_state = OFFER;
                end
            end
            OFFER: begin
                // Once offered, the descriptor stays up regardless of enable.
                if (spawn_ready) begin
                    w_count = r_count + 8'd1;
                    w_valid = 1'b0;
                    if (enable) begin
                        w_gap_cnt = w_gap_load;
                        w_state   = GAP;
                    end else begin
                        w_state   = IDLE;
                    end
                end else begin
                    w_state = OFFER;
                end
            end
            default: begin
                w_state = IDLE;
                w_valid = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_gap_cnt <= 9'd0;
            r_valid   <= 1'b0;
            r_type    <= 3'd0;
            r_x       <= 10'd0;
            r_vel     <= 4'd0;
            r_count   <= 8'd0;
        end else begin
            r_state   <= w_state;
            r_gap_cnt <= w_gap_cnt;
            r_valid   <= w_valid;
            r_type    <= w_type;
            r_x       <= w_x;
            r_vel     <= w_vel;
            r_count   <= w_count;
        end
    end

    assign spawn_valid = r_valid;
    assign spawn_type  = r_type;
    assign spawn_x     = r_x;
    assign spawn_vel   = r_vel;
    assign spawn_count = r_count;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed testbench for spawn_scheduler: a table of random-byte vectors
// with hand-computed gap lengths and descriptor fields, plus sequences for
// tick spacing, backpressure, aborts, reset mid-offer and count wrap.
module tb_spawn_scheduler;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       tick;
    logic [7:0] rand_in;
    logic       spawn_ready;
    logic       spawn_valid;
    logic [2:0] spawn_type;
    logic [9:0] spawn_x;
    logic [3:0] spawn_vel;
    logic [7:0] spawn_count;

    int tests;
    int fails;

    typedef struct {
        logic [7:0] r;
        int         n;
        int         typ;
        int         x;
        int         vel;
    } vec_t;

    vec_t vecs[6];

    spawn_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .tick        (tick),
        .rand_in     (rand_in),
        .spawn_ready (spawn_ready),
        .spawn_valid (spawn_valid),
        .spawn_type  (spawn_type),
        .spawn_x     (spawn_x),
        .spawn_vel   (spawn_vel),
        .spawn_count (spawn_count)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        enable      = 1'b0;
        tick        = 1'b0;
        spawn_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic wait_valid(input int bound, output int edges, output bit ok);
        edges = 0;
        ok    = 1'b0;
        for (int k = 0; k < bound; k++) begin
            step();
            edges++;
            if (spawn_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int edges;
        bit ok;
        int bad;
        int timeouts;

        tests = 0;
        fails = 0;
        rst = 1'b0; enable = 1'b0; tick = 1'b0; rand_in = 8'h00; spawn_ready = 1'b0;

        // r, gap ticks, type, x, vel
        vecs[0] = '{8'h00, 4,  0, 32,  4};
`ifdef SPAWN_BOMB_EN
        vecs[1] = '{8'hFF, 19, 7, 605, 11};
        vecs[2] = '{8'h27, 11, 7, 119, 5};
`else
        vecs[1] = '{8'hFF, 19, 0, 605, 11};
        vecs[2] = '{8'h27, 11, 0, 119, 5};
`endif
        vecs[3] = '{8'h5A, 14, 2, 234, 6};
        vecs[4] = '{8'h83, 7,  3, 326, 8};
        vecs[5] = '{8'hC4, 8,  4, 473, 10};

        // Reset state
        do_reset();
        step();
        chk("rst_valid", spawn_valid, 0);
        chk("rst_count", spawn_count, 0);
        chk("rst_type",  spawn_type,  0);
        chk("rst_x",     spawn_x,     0);
        chk("rst_vel",   spawn_vel,   0);

        // Table: tick every cycle, latency from enable = 1 + gap + 3
        for (int i = 0; i < 6; i++) begin
            do_reset();
            rand_in = vecs[i].r; enable = 1'b1; tick = 1'b1;
            wait_valid(200, edges, ok);
            chk($sformatf("vec%0d_latency", i), edges, vecs[i].n + 4);
            chk($sformatf("vec%0d_type", i), spawn_type, vecs[i].typ);
            chk($sformatf("vec%0d_x", i),    spawn_x,    vecs[i].x);
            chk($sformatf("vec%0d_vel", i),  spawn_vel,  vecs[i].vel);
            spawn_ready = 1'b1;
            step();
            spawn_ready = 1'b0;
            chk($sformatf("vec%0d_count", i), spawn_count, 1);
            chk($sformatf("vec%0d_drop", i),  spawn_valid, 0);
        end

        // Sparse ticks: gap holds between ticks, valid 4 cycles after last tick
        do_reset();
        rand_in = 8'h00; enable = 1'b1; tick = 1'b0;
        step();
        bad = 0;
        for (int t = 0; t < 3; t++) begin
            tick = 1'b1; step(); tick = 1'b0;
            if (spawn_valid) bad++;
            step(); if (spawn_valid) bad++;
            step(); if (spawn_valid) bad++;
        end
        chk("sparse_no_early", bad, 0);
        tick = 1'b1; step(); tick = 1'b0;
        step(); step();
        chk("last_tick_plus3", spawn_valid, 0);
        step();
        chk("last_tick_plus4", spawn_valid, 1);

        // Backpressure with ticks arriving in OFFER
        tick = 1'b1; bad = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (!spawn_valid || spawn_type != 3'd0 || spawn_x != 10'd32 ||
                spawn_vel != 4'd4 || spawn_count != 8'd0) bad++;
        end
        chk("bp_stable", bad, 0);
        enable = 1'b0;
        step(); step(); step();
        chk("offer_hold_no_enable", spawn_valid, 1);
        spawn_ready = 1'b1;
        step();
        spawn_ready = 1'b0;
        chk("bp_count_once", spawn_count, 1);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (spawn_valid) bad++;
        end
        chk("idle_after_hs", bad, 0);
        chk("idle_count", spawn_count, 1);

        // Abort in GAP, then restart from IDLE
        do_reset();
        rand_in = 8'hFF; enable = 1'b1; tick = 1'b1;
        repeat (5) step();
        enable = 1'b0;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (spawn_valid) bad++;
        end
        chk("abort_no_spawn", bad, 0);
        chk("abort_count", spawn_count, 0);
        enable = 1'b1;
        wait_valid(100, edges, ok);
        chk("restart_latency", edges, 23);
        spawn_ready = 1'b1;
        step();
        spawn_ready = 1'b0;
        chk("reload_count", spawn_count, 1);
        wait_valid(100, edges, ok);
        chk("reload_latency", edges, 22);

        // Reset mid-OFFER beats ready and enable
        spawn_ready = 1'b1; rst = 1'b0;
        step();
        chk("rst_offer_valid", spawn_valid, 0);
        chk("rst_offer_count", spawn_count, 0);
        chk("rst_offer_x",     spawn_x,     0);
        rst = 1'b1; spawn_ready = 1'b0;

        // 256 handshakes wrap the count back to 0
        do_reset();
        rand_in = 8'h00; enable = 1'b1; tick = 1'b1; spawn_ready = 1'b1;
        timeouts = 0;
        for (int h = 0; h < 256; h++) begin
            wait_valid(50, edges, ok);
            if (!ok) timeouts++;
            step();
            if (h == 254) chk("count_255", spawn_count, 255);
        end
        chk("wrap_timeouts", timeouts, 0);
        chk("count_wrap", spawn_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
